// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the control unit FSM: state encodings,
// opcodes and instruction field helpers.
package instr_fetch_unit_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_EXEC  = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;

    localparam logic [2:0] OPC_MV   = 3'b000;
    localparam logic [2:0] OPC_MVT  = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_SUB  = 3'b011;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam int INSTR_W = 16;

    // Field layout of one instruction word; bits [8:3] are not decoded.
    typedef struct packed {
        logic [2:0] opcode;
        logic       imm;
        logic [2:0] rx;
        logic [5:0] rsvd;
        logic [2:0] ry;
    } instr_t;

    function automatic logic [2:0] instr_opcode(input logic [INSTR_W-1:0] w);
        return w[15:13];
    endfunction

    function automatic logic instr_imm(input logic [INSTR_W-1:0] w);
        return w[12];
    endfunction

    function automatic logic [2:0] instr_rx(input logic [INSTR_W-1:0] w);
        return w[11:9];
    endfunction

    function automatic logic [2:0] instr_ry(input logic [INSTR_W-1:0] w);
        return w[2:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter with load, increment and decrement, wrapping modulo 2^ADDR_W.
module instr_fetch_unit_pc_counter #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= START_ADDR;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end else if (dec) begin
            pc <= pc - ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding the control unit FSM. Define PREFETCH_EN to overlap the
// next ROM read with execution of the current instruction.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [2:0]        HALT_OP    = OPC_HALT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       ir_out,
    output logic              run,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [15:0]       instr_count
);

    logic [2:0]  state, state_nxt;
    logic        pc_inc, pc_dec;
    logic        ir_load;
    logic [15:0] ir_nxt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef PREFETCH_EN
    logic        exec_first;
    logic        pf_pend;
    logic        pbuf_valid;
    logic [15:0] pbuf;
    logic [15:0] pf_word;

    // The word arriving this cycle is usable before it lands in the buffer.
    assign pf_word = pbuf_valid ? pbuf : mem_rdata;
    assign mem_rd  = (state == ST_FETCH) || ((state == ST_EXEC) && exec_first);
`else
    assign mem_rd  = (state == ST_FETCH);
`endif
    assign mem_addr = mem_rd ? pc : '0;

    instr_fetch_unit_pc_counter #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(START_ADDR)
    ) u_pc_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (1'b0),
        .load_val('0),
        .inc     (pc_inc),
        .dec     (pc_dec),
        .pc      (pc)
    );

    always_comb begin
        state_nxt = state;
        pc_inc    = 1'b0;
        pc_dec    = 1'b0;
        ir_load   = 1'b0;
        ir_nxt    = ir_out;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                pc_inc    = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                ir_load   = 1'b1;
                ir_nxt    = mem_rdata;
                state_nxt = (instr_opcode(mem_rdata) == HALT_OP) ? ST_HALT : ST_ISSUE;
            end
            ST_ISSUE: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
`ifdef PREFETCH_EN
                if (exec_first) begin
                    // A read goes out this cycle; parking now means it never advanced pc.
                    if (done && !enable) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        pc_inc = 1'b1;
                        if (done) state_nxt = ST_WAIT;
                    end
                end else if (done) begin
                    if (enable) begin
                        ir_load   = 1'b1;
                        ir_nxt    = pf_word;
                        state_nxt = (instr_opcode(pf_word) == HALT_OP) ? ST_HALT : ST_ISSUE;
                    end else begin
                        pc_dec    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
`else
                if (done) state_nxt = enable ? ST_FETCH : ST_IDLE;
`endif
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_out      <= 16'h0000;
            run         <= 1'b1;
            halted      <= 1'b0;
            instr_count <= 16'h0000;
        end else begin
            run    <= (state_nxt != ST_ISSUE);
            halted <= (state_nxt == ST_HALT);
            if (ir_load) ir_out <= ir_nxt;
            if (state_nxt == ST_ISSUE) instr_count <= sat_inc16(instr_count);
        end
    end

`ifdef PREFETCH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_first <= 1'b0;
            pf_pend    <= 1'b0;
            pbuf_valid <= 1'b0;
        end else begin
            exec_first <= (state == ST_ISSUE);
            pf_pend    <= (state == ST_EXEC) && exec_first && (state_nxt == ST_EXEC);
            pbuf_valid <= (state_nxt == ST_EXEC) && (pbuf_valid || pf_pend);
        end
    end

    always_ff @(posedge clk) begin
        if (pf_pend) pbuf <= mem_rdata;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table for the 8-bit build plus
// hand-written sequences for pc wrap on a 4-bit build and the prefetch variant.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, done;
    logic [7:0]  mem_addr, pc;
    logic        mem_rd, run, halted;
    logic [15:0] mem_rdata, ir_out, instr_count;

    logic        reset4, enable4, done4;
    logic [3:0]  mem_addr4, pc4;
    logic        mem_rd4, run4, halted4;
    logic [15:0] mem_rdata4, ir_out4, instr_count4;

    logic [15:0] rom  [256];
    logic [15:0] rom4 [16];

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.ADDR_W(8), .START_ADDR(8'h00)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .ir_out(ir_out), .run(run), .done(done), .pc(pc),
        .halted(halted), .instr_count(instr_count)
    );

    instr_fetch_unit #(.ADDR_W(4), .START_ADDR(4'hF)) u_dut4 (
        .clk(clk), .reset(reset4), .enable(enable4), .mem_addr(mem_addr4), .mem_rd(mem_rd4),
        .mem_rdata(mem_rdata4), .ir_out(ir_out4), .run(run4), .done(done4), .pc(pc4),
        .halted(halted4), .instr_count(instr_count4)
    );

    always_ff @(posedge clk) begin
        if (mem_rd)  mem_rdata  <= rom[mem_addr];
        if (mem_rd4) mem_rdata4 <= rom4[mem_addr4];
    end

    typedef struct {
        logic        rst, en, dn;
        logic        rd;
        logic [7:0]  addr;
        logic        run;
        logic [15:0] ir;
        logic [7:0]  pc;
        logic        halted;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int r, input int e, input int d, input int rd, input int addr,
                       input int rn, input int ir, input int p, input int h, input int cnt);
        vec_t v;
        v.rst = (r != 0); v.en = (e != 0); v.dn = (d != 0);
        v.rd = (rd != 0); v.addr = 8'(addr); v.run = (rn != 0); v.ir = 16'(ir);
        v.pc = 8'(p); v.halted = (h != 0); v.cnt = 16'(cnt);
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int r, input int e, input int d);
        reset = (r != 0); enable = (e != 0); done = (d != 0);
        @(negedge clk);
    endtask

    task automatic step4(input int r, input int e, input int d);
        reset4 = (r != 0); enable4 = (e != 0); done4 = (d != 0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 16; i++) rom4[i] = 16'h0000;
        rom[0] = 16'h0203; rom[1] = 16'h4405; rom[2] = 16'hE000;
        rom4[15] = 16'h0203; rom4[0] = 16'h4405;
        reset = 1'b1; enable = 1'b0; done = 1'b0;
        reset4 = 1'b1; enable4 = 1'b0; done4 = 1'b0;
        repeat (2) @(negedge clk);

`ifndef PREFETCH_EN
        //   rst en dn  rd addr run  ir       pc   h cnt
        add(1, 0, 0,  0, 0,   1, 'h0000, 0,   0, 0);  // reset state
        add(0, 1, 0,  1, 0,   1, 'h0000, 0,   0, 0);  // FETCH at 0
        add(0, 1, 0,  0, 0,   1, 'h0000, 1,   0, 0);  // WAIT
        add(0, 1, 0,  0, 0,   0, 'h0203, 1,   0, 1);  // ISSUE
        add(0, 1, 0,  0, 0,   1, 'h0203, 1,   0, 1);  // EXEC
        add(0, 1, 0,  0, 0,   1, 'h0203, 1,   0, 1);  // EXEC holds
        add(0, 1, 1,  1, 1,   1, 'h0203, 1,   0, 1);  // done -> FETCH at 1
        add(0, 1, 1,  0, 0,   1, 'h0203, 2,   0, 1);  // done in FETCH ignored
        add(0, 1, 0,  0, 0,   0, 'h4405, 2,   0, 2);  // ISSUE, 3 cycles after done
        add(0, 1, 0,  0, 0,   1, 'h4405, 2,   0, 2);
        add(0, 1, 1,  1, 2,   1, 'h4405, 2,   0, 2);  // FETCH at 2
        add(0, 1, 0,  0, 0,   1, 'h4405, 3,   0, 2);
        add(0, 1, 0,  0, 0,   1, 'hE000, 3,   1, 2);  // HALT, no run pulse
        add(0, 1, 1,  0, 0,   1, 'hE000, 3,   1, 2);
        add(0, 0, 1,  0, 0,   1, 'hE000, 3,   1, 2);
        add(1, 0, 0,  0, 0,   1, 'h0000, 0,   0, 0);  // reset leaves HALT
        add(0, 1, 0,  1, 0,   1, 'h0000, 0,   0, 0);
        add(0, 0, 0,  0, 0,   1, 'h0000, 1,   0, 0);  // enable dropped mid-fetch
        add(0, 0, 0,  0, 0,   0, 'h0203, 1,   0, 1);
        add(0, 0, 0,  0, 0,   1, 'h0203, 1,   0, 1);
        add(0, 0, 1,  0, 0,   1, 'h0203, 1,   0, 1);  // parks in IDLE
        add(0, 0, 0,  0, 0,   1, 'h0203, 1,   0, 1);
        add(0, 1, 0,  1, 1,   1, 'h0203, 1,   0, 1);
        add(0, 1, 0,  0, 0,   1, 'h0203, 2,   0, 1);
        add(0, 1, 0,  0, 0,   0, 'h4405, 2,   0, 2);
        add(0, 1, 0,  0, 0,   1, 'h4405, 2,   0, 2);
        add(1, 1, 1,  0, 0,   1, 'h0000, 0,   0, 0);  // reset wins over done in EXEC
        add(0, 0, 0,  0, 0,   1, 'h0000, 0,   0, 0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].en, vq[i].dn);
            chk($sformatf("r%0d mem_rd", i),      16'(mem_rd),      16'(vq[i].rd));
            chk($sformatf("r%0d mem_addr", i),    16'(mem_addr),    16'(vq[i].addr));
            chk($sformatf("r%0d run", i),         16'(run),         16'(vq[i].run));
            chk($sformatf("r%0d ir_out", i),      ir_out,           vq[i].ir);
            chk($sformatf("r%0d pc", i),          16'(pc),          16'(vq[i].pc));
            chk($sformatf("r%0d halted", i),      16'(halted),      16'(vq[i].halted));
            chk($sformatf("r%0d instr_count", i), instr_count,      vq[i].cnt);
        end

        chk("w4 reset pc", 16'(pc4), 16'hF);
        step4(0, 1, 0);
        chk("w4 fetch rd", 16'(mem_rd4), 16'h1);
        chk("w4 fetch addr", 16'(mem_addr4), 16'hF);
        step4(0, 1, 0);
        chk("w4 wrapped pc", 16'(pc4), 16'h0);
        step4(0, 1, 0);
        chk("w4 ir first", ir_out4, 16'h0203);
        chk("w4 run first", 16'(run4), 16'h0);
        step4(0, 1, 0);
        step4(0, 1, 1);
        chk("w4 refetch rd", 16'(mem_rd4), 16'h1);
        chk("w4 refetch addr", 16'(mem_addr4), 16'h0);
        step4(0, 1, 0);
        chk("w4 pc after 0", 16'(pc4), 16'h1);
        step4(0, 1, 0);
        chk("w4 ir second", ir_out4, 16'h4405);
        chk("w4 count", instr_count4, 16'd2);
`else
        step(1, 0, 0);
        chk("pf reset run", 16'(run), 16'h1);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("pf ir first", ir_out, 16'h0203);
        chk("pf run first", 16'(run), 16'h0);
        step(0, 1, 0);
        chk("pf exec rd", 16'(mem_rd), 16'h1);
        chk("pf exec addr", 16'(mem_addr), 16'h01);
        step(0, 1, 0);
        chk("pf pc advanced", 16'(pc), 16'h02);
        chk("pf rd once", 16'(mem_rd), 16'h0);
        step(0, 1, 0);
        step(0, 1, 1);
        chk("pf run after done", 16'(run), 16'h0);
        chk("pf ir prefetched", ir_out, 16'h4405);
        chk("pf count", instr_count, 16'd2);
        step(0, 1, 0);
        chk("pf exec2 addr", 16'(mem_addr), 16'h02);
        step(0, 1, 0);
        step(0, 0, 1);
        chk("pf pc restored", 16'(pc), 16'h02);
        chk("pf idle run", 16'(run), 16'h1);
        step(0, 0, 0);
        chk("pf idle rd", 16'(mem_rd), 16'h0);
        step(0, 1, 0);
        chk("pf refetch addr", 16'(mem_addr), 16'h02);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("pf halted", 16'(halted), 16'h1);
        chk("pf halt ir", ir_out, 16'hE000);
        step(0, 1, 1);
        chk("pf halt count", instr_count, 16'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
